cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source result FIFOs arbitrated onto a single common data bus
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     addValid,
    input  logic [ROB_W-1:0]         addRobNum,
    input  logic [DATA_W-1:0]        addData,
    output logic                     addReady,
    input  logic                     lwValid,
    input  logic [ROB_W-1:0]         lwRobNum,
    input  logic [DATA_W-1:0]        lwData,
    output logic                     lwReady,
    input  logic                     flush,
    output logic                     iscast_out,
    output logic [ROB_W-1:0]         robNum_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   addCount,
    output logic [$clog2(DEPTH):0]   lwCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ROB_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entries are stored as {robNum, data}
    logic [EW-1:0] add_mem [DEPTH];
    logic [EW-1:0] lw_mem  [DEPTH];
    logic [PW-1:0] add_rd, add_wr, lw_rd, lw_wr;

    // 1 = load unit was granted most recently, 0 = adder
    logic last_grant;

    logic push_add, push_lw, pop_add, pop_lw, add_ne, lw_ne;

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a full FIFO
    assign addReady = !reset && (addCount < FULL);
    assign lwReady  = !reset && (lwCount < FULL);

    assign push_add = addValid && addReady && !flush;
    assign push_lw  = lwValid && lwReady && !flush;

    assign add_ne = (addCount != '0);
    assign lw_ne  = (lwCount != '0);

    // Single pop per cycle; on a tie the source not granted last time wins
    assign pop_add = !flush && add_ne && (!lw_ne || last_grant);
    assign pop_lw  = !flush && lw_ne && (!add_ne || !last_grant);

    // Storage writes; contents need no reset because pointers and counts gate every read
    always_ff @(posedge clock) begin
        if (push_add) add_mem[add_wr] <= {addRobNum, addData};
        if (push_lw)  lw_mem[lw_wr]   <= {lwRobNum, lwData};
    end

    // Adder FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            add_rd   <= '0;
            add_wr   <= '0;
            addCount <= '0;
        end else if (flush) begin
            add_rd   <= '0;
            add_wr   <= '0;
            addCount <= '0;
        end else begin
            if (push_add) add_wr <= add_wr + PW'(1);
            if (pop_add)  add_rd <= add_rd + PW'(1);
            if (push_add && !pop_add)      addCount <= addCount + CW'(1);
            else if (pop_add && !push_add) addCount <= addCount - CW'(1);
        end
    end

    // Load FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lw_rd   <= '0;
            lw_wr   <= '0;
            lwCount <= '0;
        end else if (flush) begin
            lw_rd   <= '0;
            lw_wr   <= '0;
            lwCount <= '0;
        end else begin
            if (push_lw) lw_wr <= lw_wr + PW'(1);
            if (pop_lw)  lw_rd <= lw_rd + PW'(1);
            if (push_lw && !pop_lw)      lwCount <= lwCount + CW'(1);
            else if (pop_lw && !push_lw) lwCount <= lwCount - CW'(1);
        end
    end

    // Round-robin history; reset to load so the adder wins the first tie, flush leaves it alone
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (pop_add) begin
            last_grant <= 1'b0;
        end else if (pop_lw) begin
            last_grant <= 1'b1;
        end
    end

    // Registered broadcast: one-cycle strobe with the popped head, zeros otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iscast_out <= 1'b0;
            robNum_out <= '0;
            data_out   <= '0;
        end else if (pop_add) begin
            iscast_out <= 1'b1;
            robNum_out <= add_mem[add_rd][EW-1:DATA_W];
            data_out   <= add_mem[add_rd][DATA_W-1:0];
        end else if (pop_lw) begin
            iscast_out <= 1'b1;
            robNum_out <= lw_mem[lw_rd][EW-1:DATA_W];
            data_out   <= lw_mem[lw_rd][DATA_W-1:0];
        end else begin
            iscast_out <= 1'b0;
            robNum_out <= '0;
            data_out   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with a queue-based reference model
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic              addValid, lwValid, flush;
    logic [ROB_W-1:0]  addRobNum, lwRobNum;
    logic [DATA_W-1:0] addData, lwData;
    logic              addReady, lwReady, iscast_out;
    logic [ROB_W-1:0]  robNum_out;
    logic [DATA_W-1:0] data_out;
    logic [CW-1:0]     addCount, lwCount;

    cdb_arbiter #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .addValid(addValid), .addRobNum(addRobNum), .addData(addData), .addReady(addReady),
        .lwValid(lwValid), .lwRobNum(lwRobNum), .lwData(lwData), .lwReady(lwReady),
        .flush(flush), .iscast_out(iscast_out), .robNum_out(robNum_out), .data_out(data_out),
        .addCount(addCount), .lwCount(lwCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef logic [ROB_W+DATA_W-1:0] ent_t;

    int   tests = 0;
    int   fails = 0;
    ent_t add_q[$];
    ent_t lw_q[$];
    ent_t exp_q[$];
    bit   lg = 1'b1;       // 1 = load granted most recently
    bit   exp_cast = 1'b0;
    bit   saw_full = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per-source queues, round-robin on ties, pop before push
    always @(posedge clock or posedge reset) begin : model
        bit ar, lr;
        if (reset) begin
            add_q.delete();
            lw_q.delete();
            exp_q.delete();
            lg = 1'b1;
            exp_cast = 1'b0;
        end else begin
            ar = add_q.size() < DEPTH;
            lr = lw_q.size() < DEPTH;
            exp_cast = 1'b0;
            if (flush) begin
                add_q.delete();
                lw_q.delete();
            end else begin
                if (add_q.size() > 0 && (lw_q.size() == 0 || lg)) begin
                    exp_q.push_back(add_q.pop_front());
                    lg = 1'b0;
                    exp_cast = 1'b1;
                end else if (lw_q.size() > 0) begin
                    exp_q.push_back(lw_q.pop_front());
                    lg = 1'b1;
                    exp_cast = 1'b1;
                end
                if (addValid && ar) add_q.push_back({addRobNum, addData});
                if (lwValid && lr)  lw_q.push_back({lwRobNum, lwData});
            end
        end
    end

    // Monitor: compare broadcast and occupancy every cycle, away from the rising edge
    always @(negedge clock) begin : monitor
        ent_t e;
        check("iscast", iscast_out, exp_cast);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (iscast_out === 1'b1) begin
                check("robNum", robNum_out, e[ROB_W+DATA_W-1:DATA_W]);
                check("data", data_out, e[DATA_W-1:0]);
            end
        end else begin
            check("robNum_idle", robNum_out, 0);
            check("data_idle", data_out, 0);
        end
        check("addCount", addCount, add_q.size());
        check("lwCount", lwCount, lw_q.size());
        check("addReady", addReady, !reset && add_q.size() < DEPTH);
        check("lwReady", lwReady, !reset && lw_q.size() < DEPTH);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic tie_test;
        addValid = 1'b1; addRobNum = 4'd1; addData = 32'hA;
        lwValid  = 1'b1; lwRobNum  = 4'd2; lwData  = 32'hB;
        tick;
        addValid = 1'b0; lwValid = 1'b0;
        tick;
        check("tie_first_cast", iscast_out, 1);
        check("tie_first_rob", robNum_out, 1);
        tick;
        check("tie_second_cast", iscast_out, 1);
        check("tie_second_rob", robNum_out, 2);
        tick;
    endtask

    // Adder pushes 1..8 with hold-until-accepted while load traffic competes
    task automatic fill_test;
        int ai = 1;
        int li = 32'h100;
        bit aacc, lacc;
        addValid = 1'b1; addRobNum = 4'd1; addData = 32'd1;
        lwValid  = 1'b1; lwRobNum  = 4'd0; lwData  = 32'h100;
        for (int c = 0; c < 60 && ai <= 8; c++) begin
            @(negedge clock);
            aacc = addValid && addReady;
            lacc = lwValid && lwReady;
            if (addCount == CW'(DEPTH)) saw_full = 1'b1;
            tick;
            if (aacc) begin
                ai++;
                addRobNum = ROB_W'(ai);
                addData   = DATA_W'(ai);
                if (ai > 8) addValid = 1'b0;
            end
            if (lacc) begin
                li++;
                lwRobNum = ROB_W'(li);
                lwData   = DATA_W'(li);
            end
        end
        check("fill_all_accepted", ai, 9);
        addValid = 1'b0; lwValid = 1'b0;
        check("fill_reached_full", saw_full, 1);
        repeat (12) tick;
    endtask

    initial begin : stim
        int n;
        bit aacc, lacc;
        reset = 1'b1; flush = 1'b0;
        addValid = 1'b0; addRobNum = '0; addData = '0;
        lwValid = 1'b0; lwRobNum = '0; lwData = '0;
        #1;
        check("rst_addReady", addReady, 0);
        check("rst_iscast", iscast_out, 0);
        repeat (3) tick;
        reset = 1'b0;
        #1;
        check("post_rst_addReady", addReady, 1);
        check("post_rst_lwReady", lwReady, 1);
        tick;

        // Single push latency
        addValid = 1'b1; addRobNum = 4'd3; addData = 32'h11;
        tick;
        addValid = 1'b0;
        check("single_early", iscast_out, 0);
        tick;
        check("single_cast", iscast_out, 1);
        check("single_rob", robNum_out, 3);
        check("single_data", data_out, 32'h11);
        tick;
        check("single_once", iscast_out, 0);

        // Tie right after reset: adder first
        reset = 1'b1; tick; tick; reset = 1'b0; tick;
        tie_test();

        fill_test();

        // Flush with 3 pending and a same-edge push
        addValid = 1'b1; addRobNum = 4'd7; addData = 32'h70;
        lwValid  = 1'b1; lwRobNum  = 4'd8; lwData  = 32'h80;
        tick;
        addRobNum = 4'd9; addData = 32'h71;
        lwRobNum = 4'd10; lwData = 32'h81;
        tick;
        lwValid = 1'b0;
        addRobNum = 4'd11; addData = 32'hDEAD;
        flush = 1'b1;
        tick;
        flush = 1'b0; addValid = 1'b0;
        check("flush_addCount", addCount, 0);
        check("flush_lwCount", lwCount, 0);
        check("flush_iscast", iscast_out, 0);
        repeat (4) tick;

        // Reset while a broadcast is on the bus
        addValid = 1'b1; addRobNum = 4'd5; addData = 32'h55;
        lwValid  = 1'b1; lwRobNum  = 4'd6; lwData  = 32'h66;
        tick;
        addValid = 1'b0; lwValid = 1'b0;
        n = 0;
        while (iscast_out !== 1'b1 && n < 10) begin tick; n++; end
        check("rst_mid_wait_cast", iscast_out, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_iscast", iscast_out, 0);
        check("rst_mid_rob", robNum_out, 0);
        check("rst_mid_data", data_out, 0);
        check("rst_mid_counts", {addCount, lwCount}, 0);
        check("rst_mid_ready", {addReady, lwReady}, 0);
        tick; tick;
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", {addReady, lwReady}, 2'b11);
        tick;
        tie_test();

        // Load wrap: 12 pushes with idle cycles between
        for (int i = 0; i < 12; i++) begin
            lwValid = 1'b1; lwRobNum = ROB_W'(i); lwData = DATA_W'(i);
            tick;
            lwValid = 1'b0;
            tick;
        end
        repeat (3) tick;

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            aacc = addValid && addReady;
            lacc = lwValid && lwReady;
            tick;
            flush = 1'b0;
            reset = 1'b0;
            if (aacc || !addValid) begin
                addValid  = ($urandom_range(0, 2) != 0);
                addRobNum = ROB_W'($urandom);
                addData   = DATA_W'($urandom);
            end
            if (lacc || !lwValid) begin
                lwValid  = ($urandom_range(0, 2) != 0);
                lwRobNum = ROB_W'($urandom);
                lwData   = DATA_W'($urandom);
            end
            if ($urandom_range(0, 24) == 0) flush = 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                addValid = 1'b0;
                lwValid = 1'b0;
            end
        end
        reset = 1'b0; flush = 1'b0; addValid = 1'b0; lwValid = 1'b0;
        repeat (12) tick;
        check("drained_add", addCount, 0);
        check("drained_lw", lwCount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
